// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller: decodes CPU stores in a 16-byte window into
// cursor/control/status registers and a small pixel FIFO that drains into the
// framebuffer write port under a valid/ready handshake.
module io_ctrl #(
    parameter logic [31:0] IO_BASE  = 32'hFFFF_0000,
    parameter int          DEPTH    = 4,
    parameter int          FB_AW    = 13,
    parameter int          FB_WORDS = 4800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wEn,
    input  logic [31:0]      addr,
    input  logic [31:0]      dataIn,
    output logic [31:0]      dataOut,
    output logic             stall,
    output logic             fb_wEn,
    output logic [FB_AW-1:0] fb_addr,
    output logic [31:0]      fb_data,
    input  logic             fb_ready,
    output logic             io_device_id
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
    localparam logic [FB_AW-1:0] CUR_ONE  = FB_AW'(1);
    localparam logic [FB_AW-1:0] CUR_LAST = FB_AW'(FB_WORDS - 1);

    logic [FB_AW-1:0] fifo_addr_q [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [FB_AW-1:0] cursor_q, cursor_d;
    logic             enable_q, enable_d;
    logic             id_q, id_d;
    logic [31:0]      dout_q, dout_d;

    logic        hit;
    logic [3:0]  offset;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        cursor_wr;
    logic        ctrl_wr;
    logic        flush;
    logic [31:0] status;

    // Address decode, FIFO flags and handshake qualifiers.
    always_comb begin
        hit       = (addr[31:4] == IO_BASE[31:4]);
        offset    = addr[3:0];
        empty     = (count_q == '0);
        full      = (count_q == CNT_FULL);
        fb_wEn    = enable_q & ~empty;
        stall     = wEn & hit & (offset == 4'h0) & full;
        push      = wEn & hit & (offset == 4'h0) & ~full;
        pop       = fb_wEn & fb_ready;
        cursor_wr = wEn & hit & (offset == 4'h4);
        ctrl_wr   = wEn & hit & (offset == 4'h8);
        flush     = ctrl_wr & dataIn[2];
    end

    assign fb_addr      = fifo_addr_q[rd_ptr_q];
    assign fb_data      = fifo_data_q[rd_ptr_q];
    assign io_device_id = id_q;
    assign dataOut      = dout_q;

    // Next-state for pointers, cursor, control bits and the registered read data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cursor_d = cursor_q;
        enable_d = enable_q;
        id_d     = id_q;
        status   = '0;
        dout_d   = '0;

        // Flush beats a same-cycle pop; the popped word was still taken by the framebuffer.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (!push && pop) count_d = count_q - CNT_ONE;
        end

        if (push) begin
            cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + CUR_ONE;
        end else if (cursor_wr) begin
            cursor_d = (32'(dataIn[FB_AW-1:0]) >= 32'(FB_WORDS)) ? '0 : dataIn[FB_AW-1:0];
        end

        if (ctrl_wr) begin
            id_d     = dataIn[0];
            enable_d = dataIn[1];
        end

        // Reads report the state as it stands after this edge.
        status[0]      = (count_d == '0);
        status[1]      = (count_d == CNT_FULL);
        status[8+PW:8] = count_d;

        if (hit) begin
            case (offset)
                4'h4:    dout_d = 32'(cursor_d);
                4'h8:    dout_d = {30'b0, enable_d, id_d};
                4'hC:    dout_d = status;
                default: dout_d = '0;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the count guards them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cursor_q;
            fifo_data_q[wr_ptr_q] <= dataIn;
        end
    end

    // Control and status state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cursor_q <= '0;
            enable_q <= 1'b0;
            id_q     <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cursor_q <= cursor_d;
            enable_q <= enable_d;
            id_q     <= id_d;
            dout_q   <= dout_d;
        end
    end
endmodule
